bin2dec_ascii_stream: RTL and testbench



---
 rtl/ascii_pkg.sv | 31 +++
 rtl/bin2dec_ascii_stream_if.sv | 30 +++
 rtl/bin2dec_ascii_stream_dabble.sv | 22 ++
 rtl/bin2dec_ascii_stream.sv | 155 +++++++++++++++
 tb/tb_bin2dec_ascii_stream.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ascii_pkg.sv
// rtl/ascii_pkg.sv - shared state encoding, ASCII constants and digit sizing for bin2dec_ascii_stream
package ascii_pkg;

    // FSM state encoding. The values are fixed so that they stay compatible with older code.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CONV = 2'd1;
    localparam state_t ST_EMIT = 2'd2;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Returns the smallest d with 10^d > 2^data_w - 1, which is the same as 10^d >= 2^data_w.
    function automatic int min_digits(input int data_w);
        logic [127:0] lim;
        logic [127:0] pow;
        int           d;
        lim = 128'd1 << data_w;
        pow = 128'd1;
        d   = 0;
        for (int i = 0; i < 40; i++) begin
            if (pow < lim) begin
                pow = pow * 128'd10;
                d   = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2dec_ascii_stream_if.sv
// rtl/bin2dec_ascii_stream_if.sv - input word / ASCII output stream bundle for bin2dec_ascii_stream
// Signals:
//   in_valid, in_ready, in_data[DATA_W]      binary word handshake
//   out_valid, out_ready, out_data[8], out_last  ASCII byte stream
//   busy                                      converter is in CONV or EMIT
// Modports:
//   slave  - the converter
//   master - the environment, which feeds words and drains bytes
interface bin2dec_ascii_stream_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_last;
    logic              busy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/bin2dec_ascii_stream_dabble.sv
// rtl/bin2dec_ascii_stream_dabble.sv - one combinational double-dabble iteration (add-3 then shift)
// Ports:
//   bcd_in[4*DIGITS]   current BCD accumulator
//   shift_msb          bit shifted in from the binary shift register
//   bcd_out[4*DIGITS]  accumulator after adjust and shift
module bcd_dabble_step #(
    parameter int DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                shift_msb,
    output logic [4*DIGITS-1:0] bcd_out
);
    logic [4*DIGITS-1:0] adj;

    // A nibble of 5..9 becomes 8..12, so the following doubling carries correctly into the next digit.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign adj[g*4 +: 4] = (bcd_in[g*4 +: 4] >= 4'd5) ? (bcd_in[g*4 +: 4] + 4'd3)
                                                            : bcd_in[g*4 +: 4];
    end

    assign bcd_out = {adj[4*DIGITS-2:0], shift_msb};
endmodule

// File: rtl/bin2dec_ascii_stream.sv
// rtl/bin2dec_ascii_stream.sv - binary word to serial decimal ASCII stream, MSD first
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   s (slave)     in_valid/in_ready/in_data word input; out_valid/out_ready/out_data/out_last
//                 byte output; busy
// Parameters: DATA_W input width, DIGITS decimal digits, LZ_BLANK suppresses leading zeros.
// Build option: define ASCII_CRLF_EN to follow each number with CR LF; out_last then marks the LF.
module bin2dec_ascii_stream
    import ascii_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DIGITS   = 3,
    parameter int LZ_BLANK = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    bin2dec_ascii_stream_if.slave s
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(DIGITS - 1);

    if (DIGITS < min_digits(DATA_W)) begin : g_digits_check
        $error("bin2dec_ascii_stream: DIGITS too small to hold 2^DATA_W-1");
    end

    state_t             state_q;
    logic [DATA_W-1:0]  shift_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_next;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   lz_idx;
    logic               ready_q;
    logic [3:0]         cur_digit;
    logic [7:0]         out_byte;
    logic               last_byte;
    logic               emit;

`ifdef ASCII_CRLF_EN
    localparam logic [1:0] PH_DIG = 2'd0;
    localparam logic [1:0] PH_CR  = 2'd1;
    localparam logic [1:0] PH_LF  = 2'd2;
    logic [1:0] phase_q;
`endif

    bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
        .bcd_in    (bcd_q),
        .shift_msb (shift_q[DATA_W-1]),
        .bcd_out   (bcd_next)
    );

    // Highest nonzero digit of the value the last CONV step is about to store; 0 if all zero,
    // so a zero input still prints one '0'.
    always_comb begin
        lz_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_next[i*4 +: 4] != 4'd0) lz_idx = IDX_W'(i);
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) cur_digit = bcd_q[i*4 +: 4];
        end
    end

    always_comb begin
        out_byte  = ASCII_ZERO + {4'h0, cur_digit};
        last_byte = (idx_q == '0);
`ifdef ASCII_CRLF_EN
        last_byte = (phase_q == PH_LF);
        if (phase_q == PH_CR) begin
            out_byte = ASCII_CR;
        end else if (phase_q == PH_LF) begin
            out_byte = ASCII_LF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
`ifdef ASCII_CRLF_EN
            phase_q <= PH_DIG;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s.in_valid && ready_q) begin
                        shift_q <= s.in_data;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= ST_CONV;
                    end else begin
                        // Also raises in_ready one cycle after reset is released.
                        ready_q <= 1'b1;
                    end
                end
                ST_CONV: begin
                    shift_q <= shift_q << 1;
                    bcd_q   <= bcd_next;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        idx_q   <= (LZ_BLANK != 0) ? lz_idx : IDX_TOP;
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (s.out_ready) begin
`ifdef ASCII_CRLF_EN
                        case (phase_q)
                            PH_DIG: begin
                                if (idx_q == '0) phase_q <= PH_CR;
                                else             idx_q   <= idx_q - 1'b1;
                            end
                            PH_CR: phase_q <= PH_LF;
                            default: begin
                                phase_q <= PH_DIG;
                                ready_q <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        endcase
`else
                        if (idx_q == '0) begin
                            ready_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q <= idx_q - 1'b1;
                        end
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign emit        = (state_q == ST_EMIT);
    assign s.in_ready  = ready_q;
    assign s.out_valid = emit;
    assign s.out_data  = emit ? out_byte : 8'h00;
    assign s.out_last  = emit && last_byte;
    assign s.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_bin2dec_ascii_stream.sv
// tb/tb_bin2dec_ascii_stream.sv - directed self-checking bench for bin2dec_ascii_stream
module tb_bin2dec_ascii_stream;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] drv_data;
    logic [2:0]  drv_valid;
    logic        out_ready_d;
    int          sel;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_b[8];
    int          exp_n;
    int          exp_lat;

    logic        o_valid, o_last, o_busy, i_ready;
    logic [7:0]  o_data;

    always #5 clk = ~clk;

    bin2dec_ascii_stream_if #(.DATA_W(8))  if0 ();
    bin2dec_ascii_stream_if #(.DATA_W(8))  if1 ();
    bin2dec_ascii_stream_if #(.DATA_W(16)) if2 ();

    assign if0.in_valid  = drv_valid[0];
    assign if0.in_data   = drv_data[7:0];
    assign if0.out_ready = out_ready_d;
    assign if1.in_valid  = drv_valid[1];
    assign if1.in_data   = drv_data[7:0];
    assign if1.out_ready = out_ready_d;
    assign if2.in_valid  = drv_valid[2];
    assign if2.in_data   = drv_data;
    assign if2.out_ready = out_ready_d;

    bin2dec_ascii_stream #(.DATA_W(8),  .DIGITS(3), .LZ_BLANK(0)) u0 (.clk(clk), .rst(rst), .s(if0));
    bin2dec_ascii_stream #(.DATA_W(8),  .DIGITS(3), .LZ_BLANK(1)) u1 (.clk(clk), .rst(rst), .s(if1));
    bin2dec_ascii_stream #(.DATA_W(16), .DIGITS(5), .LZ_BLANK(0)) u2 (.clk(clk), .rst(rst), .s(if2));

    always_comb begin
        o_valid = if0.out_valid; o_last = if0.out_last; o_busy = if0.busy;
        i_ready = if0.in_ready;  o_data = if0.out_data;
        if (sel == 1) begin
            o_valid = if1.out_valid; o_last = if1.out_last; o_busy = if1.busy;
            i_ready = if1.in_ready;  o_data = if1.out_data;
        end else if (sel == 2) begin
            o_valid = if2.out_valid; o_last = if2.out_last; o_busy = if2.busy;
            i_ready = if2.in_ready;  o_data = if2.out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        bit ok;
        ok = 1'b0;
        drv_data       = v;
        drv_valid[sel] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i_ready) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        drv_valid[sel] = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept(%0d): in_ready never seen, required 1", v);
        end
    endtask

    task automatic collect(input bit rand_bp, input string name);
        int         k;
        int         cyc;
        bit         first;
        bit         stalled;
        logic [7:0] hold_d;
        logic       hold_l;
        k = 0; cyc = 1; first = 1'b1; stalled = 1'b0; hold_d = 8'h00; hold_l = 1'b0;
        while (k < exp_n && cyc < 400) begin
            if (stalled) begin
                n_checks++;
                if (!o_valid || o_data !== hold_d || o_last !== hold_l) begin
                    n_fail++;
                    $display("FAIL %s stall: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                             name, o_valid, o_data, o_last, hold_d, hold_l);
                end
            end
            if (o_busy && i_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s in_ready while busy: in_ready=%b required 0", name, i_ready);
            end
            if (o_valid && first) begin
                first = 1'b0;
                n_checks++;
                if (cyc != exp_lat) begin
                    n_fail++;
                    $display("FAIL %s latency: %0d cycles required %0d", name, cyc, exp_lat);
                end
            end
            out_ready_d = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_valid && out_ready_d) begin
                n_checks++;
                if (o_data !== exp_b[k] || o_last !== 1'(k == exp_n - 1)) begin
                    n_fail++;
                    $display("FAIL %s byte%0d: data=%h last=%b required data=%h last=%b",
                             name, k, o_data, o_last, exp_b[k], (k == exp_n - 1));
                end
                k++;
                stalled = 1'b0;
            end else begin
                stalled = o_valid;
                hold_d  = o_data;
                hold_l  = o_last;
            end
            step();
            cyc++;
        end
        out_ready_d = 1'b1;
        n_checks++;
        if (k != exp_n) begin
            n_fail++;
            $display("FAIL %s count: %0d bytes required %0d", name, k, exp_n);
        end
        n_checks++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done: in_ready=%b valid=%b busy=%b required 1 0 0",
                     name, i_ready, o_valid, o_busy);
        end
    endtask

    task automatic test_reset();
        sel = 0;
        rst = 1'b1; drv_data = 16'd99; drv_valid = 3'b001;
        step(); step();
        n_checks++;
        if (i_ready !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_data !== 8'h00 || o_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: ready=%b valid=%b busy=%b data=%h last=%b required 0 0 0 00 0",
                     i_ready, o_valid, o_busy, o_data, o_last);
        end
        rst = 1'b0;
        step();
        drv_valid = 3'b000;
        n_checks++;
        if (i_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset release: in_ready=%b busy=%b required 1 0", i_ready, o_busy);
        end
        step();
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset capture: busy=%b required 0", o_busy);
        end
    endtask

    task automatic test_full_scale();
        sel = 0;
        send(16'd255);
        exp_b[0] = 8'h32; exp_b[1] = 8'h35; exp_b[2] = 8'h35; exp_n = 3; exp_lat = 9;
        collect(1'b0, "ff");
    endtask

    task automatic test_leading_zeros();
        sel = 0;
        send(16'd7);
        exp_b[0] = 8'h30; exp_b[1] = 8'h30; exp_b[2] = 8'h37; exp_n = 3; exp_lat = 9;
        collect(1'b0, "seven_lz0");
        sel = 1;
        send(16'd7);
        exp_b[0] = 8'h37; exp_n = 1; exp_lat = 9;
        collect(1'b0, "seven_lz1");
        send(16'd0);
        exp_b[0] = 8'h30; exp_n = 1; exp_lat = 9;
        collect(1'b0, "zero_lz1");
    endtask

    task automatic test_wide();
        sel = 2;
        send(16'd65535);
        exp_b[0] = 8'h36; exp_b[1] = 8'h35; exp_b[2] = 8'h35; exp_b[3] = 8'h33; exp_b[4] = 8'h35;
        exp_n = 5; exp_lat = 17;
        collect(1'b0, "wide");
    endtask

    task automatic test_back_to_back();
        sel = 0;
        send(16'd123);
        drv_data = 16'd45; drv_valid[0] = 1'b1;
        exp_b[0] = 8'h31; exp_b[1] = 8'h32; exp_b[2] = 8'h33; exp_n = 3; exp_lat = 9;
        collect(1'b1, "bp123");
        send(16'd45);
        exp_b[0] = 8'h30; exp_b[1] = 8'h34; exp_b[2] = 8'h35; exp_n = 3; exp_lat = 9;
        collect(1'b1, "held45");
    endtask

    task automatic test_reset_mid();
        sel = 0;
        out_ready_d = 1'b1;
        send(16'd255);
        for (int i = 0; i < 20 && !o_valid; i++) step();
        step();
        n_checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h35) begin
            n_fail++;
            $display("FAIL midrst second byte: valid=%b data=%h required 1 35", o_valid, o_data);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || i_ready !== 1'b0 || o_data !== 8'h00 || o_last !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: valid=%b busy=%b ready=%b data=%h last=%b required 0 0 0 00 0",
                     o_valid, o_busy, i_ready, o_data, o_last);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (i_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst release: in_ready=%b busy=%b required 1 0", i_ready, o_busy);
        end
        send(16'd42);
        exp_b[0] = 8'h30; exp_b[1] = 8'h34; exp_b[2] = 8'h32; exp_n = 3; exp_lat = 9;
        collect(1'b0, "after_rst42");
    endtask

    task automatic test_crlf();
        sel = 0;
        send(16'd200);
        exp_b[0] = 8'h32; exp_b[1] = 8'h30; exp_b[2] = 8'h30;
`ifdef ASCII_CRLF_EN
        exp_b[3] = 8'h0D; exp_b[4] = 8'h0A; exp_n = 5;
`else
        exp_n = 3;
`endif
        exp_lat = 9;
        collect(1'b1, "two_hundred");
    endtask

    initial begin
        rst = 1'b1; drv_data = '0; drv_valid = '0; out_ready_d = 1'b1; sel = 0;
        test_reset();
        test_full_scale();
        test_leading_zeros();
        test_wide();
        test_back_to_back();
        test_reset_mid();
        test_crlf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
